seed_current_monitor: RTL and testbench
=======================================

// Module: seed_current_monitor
// PURPOSE
//   Parametrised multi-channel over-current monitor for the seed laser driver.
//   Compares each NUM_CH-wide ADC sample against a DDS or CW limit set.
//   Requires TRIP_THRESH consecutive over-limit samples before tripping.
//   Latches per-channel faults, drives a shutdown_n interlock, and tracks per-channel peaks.
//   Sits between adc_control sample outputs and the laser disable / I2C status registers.
// PARAMETERS
//   NUM_CH   2   number of monitored channels
//   DATA_W   16  sample and limit width (unsigned)
//   CNT_W    4   width of consecutive-sample counter and trip_thresh
// PORTS
//   clk           in   1              system clock (10 MHz)
//   rstn          in   1              reset, synchronous, active-low
//   sample_valid  in   1              one-cycle strobe; sample_data valid this cycle
//   sample_data   in   NUM_CH*DATA_W  ch0 in [DATA_W-1:0]
//   limit_sel     in   1              0 = use limit_dds, 1 = use limit_cw
//   limit_dds     in   NUM_CH*DATA_W  DDS-mode limits
//   limit_cw      in   NUM_CH*DATA_W  CW-mode limits
//   limit_update  in   1              pulse: copy both limit sets into shadow registers
//   trip_thresh   in   CNT_W          consecutive over-limit samples to trip; 0 treated as 1
//   arm           in   1              1 = monitoring enabled (laser active)
//   status_clear  in   1              pulse: clear faults, counters, peaks
//   over_limit    out  NUM_CH         per-channel result of last compared sample
//   fault_latched out  NUM_CH         sticky per-channel trip flags
//   shutdown_n    out  1              0 while any fault_latched bit is set
//   peak_data     out  NUM_CH*DATA_W  max sample since last clear/reset
// BEHAVIOUR
//   Reset (rstn=0 at clk edge):
//     - shadow limits = all ones; counters = 0
//     - over_limit = 0, fault_latched = 0, peak_data = 0, shutdown_n = 1
//   Limits:
//     - comparisons use shadow limits only; limit_update loads the shadows next edge
//     - a sample in the same cycle as limit_update compares against the OLD shadows
//     - limit_sel is sampled with sample_valid, per sample
//   Compare: over = sample > limit (strict, unsigned); registered into over_limit, latency 1.
//   Per-channel FSM, updated only on sample_valid:
//     DISARMED  - arm=0: counter forced 0, no new trips; existing faults kept
//     MONITOR   - over=0: counter=0; over=1: counter+1 -> COUNTING, or TRIPPED if counter+1>=thr
//     COUNTING  - over=1: counter+1; trip when counter+1>=thr; over=0: counter=0 -> MONITOR
//     TRIPPED   - fault_latched=1, counter saturates; exit only via status_clear or reset
//     arm 1->0 from MONITOR/COUNTING -> DISARMED; 0->1 -> MONITOR with counter 0
//   Trip timing:
//     - fault_latched set at the same edge as over_limit (1 clk after the tripping sample)
//     - shutdown_n = ~|fault_latched, combinational from registers
//   Counter: saturates at 2^CNT_W-1, never wraps; thr=0 behaves as thr=1.
//   status_clear:
//     - clears fault_latched, counters, peak_data
//     - a trip in the same cycle wins: fault set, counter=1
//     - peak_data loads the coincident sample, not 0
//   Peak: on sample_valid, peak = max(peak, sample), independent of arm.
//   Non-valid cycles: all state holds.
//   rstn low mid-count returns everything to reset values at the next edge.
// TESTING
//   - Reset, no stimulus -> shutdown_n=1, fault_latched=0, peak_data=0; limits all ones, so 0xFFFF never trips.
//   - limit_update dds ch0=0x1000, thr=3, arm=1; samples 0x1001 x3 -> fault_latched[0]=1 one clk after 3rd; shutdown_n=0.
//   - Same setup, 0x1001,0x1001,0x0FFF,0x1001,0x1001 -> no trip (counter resets); a sample of exactly 0x1000 never counts.
//   - status_clear coincident with 3rd over-limit sample -> fault remains set; clear alone next cycle -> fault=0, shutdown_n=1, peak=0.
//   - limit_sel toggles: cw ch1=0x0200, dds ch1=0x8000, sample 0x0300 -> trips only when limit_sel=1.
//   - arm=0 with samples 0xFFFF, thr=1 -> no fault; peak_data=0xFFFF. thr=0 with arm=1 -> trip on first over-limit sample.

Source files
------------

// File: rtl/seed_current_monitor.sv
// Multi-channel over-current monitor for the seed laser driver: shadowed DDS/CW limits,
// consecutive-sample trip qualification, sticky faults, shutdown interlock and peak tracking.
module seed_current_monitor #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic                     limit_sel,
  input  logic [NUM_CH*DATA_W-1:0] limit_dds,
  input  logic [NUM_CH*DATA_W-1:0] limit_cw,
  input  logic                     limit_update,
  input  logic [CNT_W-1:0]         trip_thresh,
  input  logic                     arm,
  input  logic                     status_clear,
  output logic [NUM_CH-1:0]        over_limit,
  output logic [NUM_CH-1:0]        fault_latched,
  output logic                     shutdown_n,
  output logic [NUM_CH*DATA_W-1:0] peak_data
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_MONITOR  = 2'd1,
    ST_COUNTING = 2'd2,
    ST_TRIPPED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NUM_CH*DATA_W-1:0] shadow_dds_r;
  logic [NUM_CH*DATA_W-1:0] shadow_cw_r;
  logic [CNT_W-1:0]         thr_eff_s;

  // Shadow limit registers; comparisons never see the live limit inputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow_dds_r <= '1;
      shadow_cw_r  <= '1;
    end else if (limit_update) begin
      shadow_dds_r <= limit_dds;
      shadow_cw_r  <= limit_cw;
    end else begin
      shadow_dds_r <= shadow_dds_r;
      shadow_cw_r  <= shadow_cw_r;
    end
  end

  // A threshold of zero is treated as one so a single over-limit sample trips.
  always_comb begin
    if (trip_thresh == CNT_ZERO) begin
      thr_eff_s = CNT_ONE;
    end else begin
      thr_eff_s = trip_thresh;
    end
  end

  assign shutdown_n = ~|fault_latched;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] sample_s;
    logic [DATA_W-1:0] limit_s;
    logic              over_s;
    logic [CNT_W-1:0]  cnt_base_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              trip_s;
    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              over_r;
    logic              fault_r;
    logic [DATA_W-1:0] peak_r;

    // Compare against the selected shadow limit and qualify a new trip.
    always_comb begin
      sample_s = sample_data[ch*DATA_W +: DATA_W];
      if (limit_sel) begin
        limit_s = shadow_cw_r[ch*DATA_W +: DATA_W];
      end else begin
        limit_s = shadow_dds_r[ch*DATA_W +: DATA_W];
      end
      over_s = (sample_s > limit_s);
      if (state_r == ST_DISARMED) begin
        cnt_base_s = CNT_ZERO;
      end else begin
        cnt_base_s = cnt_r;
      end
      if (cnt_base_s == CNT_MAX) begin
        cnt_inc_s = cnt_base_s;
      end else begin
        cnt_inc_s = cnt_base_s + CNT_ONE;
      end
      trip_s = sample_valid && arm && over_s && (state_r != ST_TRIPPED) &&
               (cnt_inc_s >= thr_eff_s);
    end

    // Channel FSM, compare register and peak tracker; a coincident trip beats status_clear.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        state_r <= ST_DISARMED;
        cnt_r   <= CNT_ZERO;
        over_r  <= 1'b0;
        fault_r <= 1'b0;
        peak_r  <= '0;
      end else begin
        if (sample_valid) begin
          over_r <= over_s;
        end else begin
          over_r <= over_r;
        end

        if (status_clear) begin
          peak_r <= sample_valid ? sample_s : '0;
        end else if (sample_valid && (sample_s > peak_r)) begin
          peak_r <= sample_s;
        end else begin
          peak_r <= peak_r;
        end

        if (trip_s) begin
          state_r <= ST_TRIPPED;
          fault_r <= 1'b1;
          cnt_r   <= status_clear ? CNT_ONE : cnt_inc_s;
        end else if (status_clear) begin
          state_r <= arm ? ST_MONITOR : ST_DISARMED;
          fault_r <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end else if (sample_valid) begin
          case (state_r)
            ST_TRIPPED: begin
              fault_r <= 1'b1;
              cnt_r   <= over_s ? cnt_inc_s : cnt_r;
            end
            ST_DISARMED, ST_MONITOR, ST_COUNTING: begin
              if (!arm) begin
                state_r <= ST_DISARMED;
                cnt_r   <= CNT_ZERO;
              end else if (over_s) begin
                state_r <= ST_COUNTING;
                cnt_r   <= cnt_inc_s;
              end else begin
                state_r <= ST_MONITOR;
                cnt_r   <= CNT_ZERO;
              end
            end
            default: begin
              state_r <= ST_DISARMED;
              cnt_r   <= CNT_ZERO;
            end
          endcase
        end else begin
          state_r <= state_r;
          cnt_r   <= cnt_r;
          fault_r <= fault_r;
        end
      end
    end

    assign over_limit[ch]                 = over_r;
    assign fault_latched[ch]              = fault_r;
    assign peak_data[ch*DATA_W +: DATA_W] = peak_r;
  end

endmodule

// File: tb/tb_seed_current_monitor.sv
// Scoreboard bench for seed_current_monitor: a behavioural model pushes expected outputs
// per driven cycle, and they are popped and compared one clock later.
module tb_seed_current_monitor;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        limit_sel;
  logic [31:0] limit_dds;
  logic [31:0] limit_cw;
  logic        limit_update;
  logic [3:0]  trip_thresh;
  logic        arm;
  logic        status_clear;
  logic [1:0]  over_limit;
  logic [1:0]  fault_latched;
  logic        shutdown_n;
  logic [31:0] peak_data;

  typedef struct packed {
    logic [1:0]  over;
    logic [1:0]  fault;
    logic        sd;
    logic [31:0] peak;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [15:0] m_dds[2];
  logic [15:0] m_cw[2];
  logic [15:0] m_peak[2];
  logic        m_over[2];
  logic        m_fault[2];
  int          m_cnt[2];

  always #50 clk = ~clk;

  seed_current_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .sample_data(sample_data),
    .limit_sel(limit_sel), .limit_dds(limit_dds), .limit_cw(limit_cw),
    .limit_update(limit_update), .trip_thresh(trip_thresh), .arm(arm),
    .status_clear(status_clear), .over_limit(over_limit), .fault_latched(fault_latched),
    .shutdown_n(shutdown_n), .peak_data(peak_data)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Reference behaviour evaluated from the inputs present for the coming edge.
  task automatic model_update();
    int thr_eff;
    logic [15:0] s;
    logic [15:0] lim;
    logic ov;
    logic trip;
    if (!rstn) begin
      for (int c = 0; c < 2; c++) begin
        m_dds[c] = 16'hFFFF; m_cw[c] = 16'hFFFF; m_peak[c] = 16'h0000;
        m_over[c] = 1'b0; m_fault[c] = 1'b0; m_cnt[c] = 0;
      end
    end else begin
      thr_eff = (trip_thresh == 4'd0) ? 1 : int'(trip_thresh);
      for (int c = 0; c < 2; c++) begin
        s    = sample_data[c*16 +: 16];
        lim  = limit_sel ? m_cw[c] : m_dds[c];
        ov   = (s > lim);
        trip = sample_valid && arm && ov && !m_fault[c] && (m_cnt[c] + 1 >= thr_eff);
        if (sample_valid) m_over[c] = ov;
        if (status_clear) m_peak[c] = sample_valid ? s : 16'h0000;
        else if (sample_valid && s > m_peak[c]) m_peak[c] = s;
        if (trip) begin
          m_fault[c] = 1'b1;
          m_cnt[c]   = status_clear ? 1 : m_cnt[c] + 1;
        end else if (status_clear) begin
          m_fault[c] = 1'b0;
          m_cnt[c]   = 0;
        end else if (sample_valid && !m_fault[c]) begin
          if (!arm || !ov) m_cnt[c] = 0;
          else if (m_cnt[c] < 15) m_cnt[c] = m_cnt[c] + 1;
        end
      end
      if (limit_update) begin
        m_dds[0] = limit_dds[15:0]; m_dds[1] = limit_dds[31:16];
        m_cw[0]  = limit_cw[15:0];  m_cw[1]  = limit_cw[31:16];
      end
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_update();
    e.over  = {m_over[1], m_over[0]};
    e.fault = {m_fault[1], m_fault[0]};
    e.sd    = ~(m_fault[0] | m_fault[1]);
    e.peak  = {m_peak[1], m_peak[0]};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".over"},  {30'd0, over_limit},    {30'd0, e.over});
    check_val({tag, ".fault"}, {30'd0, fault_latched}, {30'd0, e.fault});
    check_val({tag, ".sd"},    {31'd0, shutdown_n},    {31'd0, e.sd});
    check_val({tag, ".peak"},  peak_data,              e.peak);
    sample_valid = 1'b0; limit_update = 1'b0; status_clear = 1'b0; rstn = 1'b1;
  endtask

  task automatic samp(input logic [15:0] c1, input logic [15:0] c0, input string tag);
    sample_valid = 1'b1;
    sample_data  = {c1, c0};
    step(tag);
  endtask

  task automatic clear_only(input string tag);
    status_clear = 1'b1;
    step(tag);
  endtask

  initial begin
    rstn = 1'b0; sample_valid = 1'b0; sample_data = 32'd0; limit_sel = 1'b0;
    limit_dds = 32'd0; limit_cw = 32'd0; limit_update = 1'b0; trip_thresh = 4'd1;
    arm = 1'b1; status_clear = 1'b0;
    @(negedge clk);
    rstn = 1'b0; step("rst0");
    rstn = 1'b0; step("rst1");
    check_val("rst_sd_const", {31'd0, shutdown_n}, 32'd1);
    check_val("rst_peak_const", peak_data, 32'd0);

    // All-ones shadow limits: full scale never trips.
    samp(16'hFFFF, 16'hFFFF, "ffff_no_trip");
    clear_only("clr0");

    limit_dds = {16'h8000, 16'h1000}; limit_cw = {16'h0200, 16'h2000};
    limit_update = 1'b1; step("lim_load");
    trip_thresh = 4'd3;
    samp(16'h0000, 16'h1001, "t3_a");
    samp(16'h0000, 16'h1001, "t3_b");
    samp(16'h0000, 16'h1001, "t3_trip");
    check_val("t3_fault_const", {30'd0, fault_latched}, 32'd1);
    clear_only("clr1");

    samp(16'h0000, 16'h1001, "seq_a");
    samp(16'h0000, 16'h1001, "seq_b");
    samp(16'h0000, 16'h0FFF, "seq_gap");
    samp(16'h0000, 16'h1001, "seq_c");
    samp(16'h0000, 16'h1001, "seq_d");
    for (int i = 0; i < 4; i++) samp(16'h8000, 16'h1000, "equal_limit");
    check_val("equal_no_fault", {30'd0, fault_latched}, 32'd0);
    clear_only("clr2");

    samp(16'h0000, 16'h1001, "clr_race_a");
    samp(16'h0000, 16'h1001, "clr_race_b");
    status_clear = 1'b1; samp(16'h0000, 16'h1001, "clr_race_trip");
    clear_only("clr_after");
    check_val("clr_after_peak", peak_data, 32'd0);

    trip_thresh = 4'd1;
    limit_sel = 1'b0; samp(16'h0300, 16'h0000, "sel_dds");
    limit_sel = 1'b1; samp(16'h0300, 16'h0000, "sel_cw");
    clear_only("clr3");

    arm = 1'b0; limit_sel = 1'b0;
    for (int i = 0; i < 3; i++) samp(16'hFFFF, 16'hFFFF, "disarmed");
    arm = 1'b1; trip_thresh = 4'd0;
    samp(16'h0000, 16'h1001, "thr0_trip");
    clear_only("clr4");

    // Limit update coincident with a sample: old shadow still applies.
    limit_dds = {16'h8000, 16'hF000}; limit_update = 1'b1;
    samp(16'h0000, 16'h2000, "upd_race");
    samp(16'h0000, 16'h2000, "upd_new");
    clear_only("clr5");

    trip_thresh = 4'd15;
    for (int i = 0; i < 17; i++) samp(16'h0000, 16'hF001, "sat");
    step("idle_hold");
    trip_thresh = 4'd3;
    samp(16'h0000, 16'hF001, "mid_a");
    rstn = 1'b0; samp(16'h0000, 16'hF001, "mid_rst");
    samp(16'h0000, 16'hF001, "post_rst");

    limit_dds = {16'h0200, 16'h1000}; limit_cw = {16'h0100, 16'h0800};
    limit_update = 1'b1; step("rnd_lim");
    for (int i = 0; i < 200; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_data  = {16'($urandom_range(0, 16'h0300)), 16'($urandom_range(16'h0700, 16'h1100))};
      limit_sel    = 1'($urandom_range(0, 1));
      arm          = ($urandom_range(0, 7) != 0);
      status_clear = ($urandom_range(0, 15) == 0);
      trip_thresh  = 4'($urandom_range(0, 4));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
